frame_stream_buf: RTL and testbench

Parametrised frame buffer between the image-processing pipeline and the UART TX path. Random-access write port fills a frame of `DATA_W`-bit pixels; on `frame_tick` the frame streams out in raster order over a valid/ready interface with end-of-line and end-of-frame markers. An optional ping-pong bank pair lets the next frame be written while the current one streams. Overrun of the streaming side is detected and flagged.

---
 rtl/frame_stream_pkg.sv | 10 +
 rtl/fs_bank_ram.sv | 29 ++
 rtl/frame_stream_buf.sv | 147 ++++++++++++++
 tb/tb_frame_stream_buf.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_stream_pkg.sv
// Shared types for the frame stream buffer: streaming FSM state encoding.
package frame_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } fs_state_t;

endpackage

// File: rtl/fs_bank_ram.sv
// One frame bank: simple dual-port RAM, synchronous read-first port with a
// resettable output register that holds its value while the read is disabled.
module fs_bank_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_stream_buf.sv
// Frame buffer streaming a raster frame over valid/ready with eol/last markers.
// Define FRAME_STREAM_PINGPONG_EN for a ping-pong bank pair (write next frame while streaming).
module frame_stream_buf
  import frame_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 30,
  parameter int IMG_H  = 170,
  parameter int DEPTH  = IMG_W * IMG_H,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic              frame_tick,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_eol,
  output logic              rd_last,
  output logic              frame_busy,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam int                COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);

  fs_state_t         state;
  logic [ADDR_W-1:0] addr;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] addr_nxt;
  logic [COL_W-1:0]  col_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic              hs;
  logic              tick_take;
  logic              wr_ok;
  logic              rd_en;

  assign hs        = rd_valid && rd_ready;
  assign tick_take = frame_tick && ((state == IDLE) || (hs && rd_last));
  assign wr_ok     = we && (wAddr <= LAST_ADDR);
  assign addr_nxt  = addr + ADDR_W'(1);
  assign col_nxt   = (col == LAST_COL) ? '0 : col + COL_W'(1);

  // Read-ahead: fetch the next pixel on the handshake so the RAM register
  // already holds it on the following cycle; no fetch while stalled keeps data stable.
  assign rd_en   = (state == PRIME) || (hs && !rd_last);
  assign rd_addr = (state == PRIME) ? '0 : addr_nxt;

`ifdef FRAME_STREAM_PINGPONG_EN
  logic              rd_bank;
  logic [DATA_W-1:0] bank_q_p1 [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fs_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (wr_ok && (rd_bank != 1'(b))),
      .waddr (wAddr),
      .wdata (wData),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (bank_q_p1[b])
    );
  end

  assign rd_data = bank_q_p1[rd_bank];

  always_ff @(posedge clk) begin
    if (!reset)         rd_bank <= 1'b0;
    else if (tick_take) rd_bank <= ~rd_bank;
  end
`else
  fs_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok),
    .waddr (wAddr),
    .wdata (wData),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= '0;
      col        <= '0;
      rd_valid   <= 1'b0;
      rd_eol     <= 1'b0;
      rd_last    <= 1'b0;
      frame_busy <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // A dropped tick outranks a same-cycle clear.
      if (frame_tick && !tick_take) overrun <= 1'b1;
      else if (ovr_clr)             overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (tick_take) begin
            state      <= PRIME;
            addr       <= '0;
            col        <= '0;
            frame_busy <= 1'b1;
          end
        end
        PRIME: begin
          state    <= STREAM;
          rd_valid <= 1'b1;
          rd_eol   <= (LAST_COL == '0);
          rd_last  <= (LAST_ADDR == '0);
        end
        STREAM: begin
          if (hs) begin
            if (rd_last) begin
              rd_valid <= 1'b0;
              rd_eol   <= 1'b0;
              rd_last  <= 1'b0;
              if (tick_take) begin
                state <= PRIME;
                addr  <= '0;
                col   <= '0;
              end else begin
                state      <= IDLE;
                frame_busy <= 1'b0;
              end
            end else begin
              addr    <= addr_nxt;
              col     <= col_nxt;
              rd_eol  <= (col_nxt == LAST_COL);
              rd_last <= (addr_nxt == LAST_ADDR);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_stream_buf.sv
// Directed bench for frame_stream_buf: table of whole-frame scenarios plus
// hand-written reset, back-to-back and bank-sharing sequences.
module tb_frame_stream_buf;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 30;
  localparam int IMG_H  = 170;
  localparam int DEPTH  = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset, we, frame_tick, rd_ready, ovr_clr;
  logic [ADDR_W-1:0] wAddr;
  logic [DATA_W-1:0] wData;
  logic              rd_valid, rd_eol, rd_last, frame_busy, overrun;
  logic [DATA_W-1:0] rd_data;

  always #5 clk = ~clk;

  frame_stream_buf #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .wAddr      (wAddr),
    .wData      (wData),
    .frame_tick (frame_tick),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_eol     (rd_eol),
    .rd_last    (rd_last),
    .frame_busy (frame_busy),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  typedef struct {
    bit rnd;
    int pat;
    int tick_a;
    int clr_a;
    int tick_b;
    int clr_b;
    int exp_cyc;
    bit exp_ovr;
  } vec_t;

  vec_t tbl [3];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   exp_ovr = 1'b0;
  int   npx, nbad, neol, nlast, ncyc, nside, bad_px;
  int   first_pat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // pat 0: addr[7:0], pat 1: ~addr[7:0], pat 2: torn frame (A low, B high, middle unchecked)
  function automatic int exp_pix(input int pat, input int a);
    case (pat)
      0:       return a & 255;
      1:       return (~a) & 255;
      default: return (a < 2000) ? (a & 255) : (a > 3000) ? ((~a) & 255) : -1;
    endcase
  endfunction

  task automatic write_frame(input int pat, input bit desc);
    int a;
    for (int i = 0; i < DEPTH; i++) begin
      a     = desc ? (DEPTH - 1 - i) : i;
      we    = 1'b1;
      wAddr = ADDR_W'(a);
      wData = DATA_W'((pat == 1) ? ~a : a);
      @(negedge clk);
    end
    we = 1'b0;
  endtask

  task automatic issue_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Entered at the negedge right after the tick edge; leaves at the negedge after the last handshake.
  task automatic stream_frame(input bit rnd, input int pat, input int tick_a, input int clr_a,
                              input int tick_b, input int clr_b, input bit tick_last,
                              output int o_npx, output int o_nbad, output int o_neol,
                              output int o_nlast, output int o_ncyc, output int o_nside,
                              output int o_bad_px);
    bit hs, done;
    int e, k;
    o_npx = 0; o_nbad = 0; o_neol = 0; o_nlast = 0; o_nside = 0; o_bad_px = -1;
    done = 1'b0;
    k = 0;
    while (!done && k < 30000) begin
      if (overrun !== exp_ovr || frame_busy !== 1'b1) o_nside++;
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = (rd_valid === 1'b1) && rd_ready;
      if (rd_valid === 1'b1) begin
        e = exp_pix(pat, o_npx);
        if ((e >= 0 && rd_data !== DATA_W'(e)) ||
            rd_eol !== (o_npx % IMG_W == IMG_W - 1) ||
            rd_last !== (o_npx == DEPTH - 1)) begin
          if (o_nbad == 0) o_bad_px = o_npx;
          o_nbad++;
        end
        if (hs && rd_eol)  o_neol++;
        if (hs && rd_last) o_nlast++;
      end
      frame_tick = hs && ((o_npx == tick_a) || (o_npx == tick_b) ||
                          (tick_last && o_npx == DEPTH - 1));
      ovr_clr    = hs && ((o_npx == clr_a) || (o_npx == clr_b));
      if (frame_tick && !(hs && o_npx == DEPTH - 1)) exp_ovr = 1'b1;
      else if (ovr_clr)                               exp_ovr = 1'b0;
      if (hs) begin
        if (o_npx == DEPTH - 1) done = 1'b1;
        o_npx++;
      end
      @(negedge clk);
      k++;
    end
    frame_tick = 1'b0;
    ovr_clr    = 1'b0;
    o_ncyc     = k;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, rd_valid, 0);
    check({tag, "_data"},  rd_data, 0);
    check({tag, "_eol"},   rd_eol, 0);
    check({tag, "_last"},  rd_last, 0);
    check({tag, "_busy"},  frame_busy, 0);
    check({tag, "_ovr"},   overrun, 0);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_pixels"}, npx, DEPTH);
    check($sformatf("%s_pixerr(first bad px %0d)", tag, bad_px), nbad, 0);
    check({tag, "_eolcnt"}, neol, IMG_H);
    check({tag, "_lastcnt"}, nlast, 1);
    check({tag, "_busy_ovr_track"}, nside, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; we = 1'b0; wAddr = '0; wData = '0;
    frame_tick = 1'b0; rd_ready = 1'b0; ovr_clr = 1'b0;

    //            rnd pat tick_a clr_a tick_b clr_b exp_cyc exp_ovr
    tbl[0] = '{1'b0, 0,    -1,    -1,    -1,    -1,   5101,  1'b0};
    tbl[1] = '{1'b1, 1,    -1,    -1,    -1,    -1,     -1,  1'b0};
    tbl[2] = '{1'b0, 0,  2000,  3000,  3500,  3500,   5101,  1'b1};

    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    reset = 1'b1;
    @(negedge clk);

    // Reset in the middle of a stream, then a fresh frame restarts at address 0
    write_frame(0, 1'b0);
    rd_ready = 1'b1;
    issue_tick();
    repeat (101) @(negedge clk);
    check("mid_valid", rd_valid, 1);
    check("mid_data", rd_data, 100);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    repeat (3) @(negedge clk);
    check("midrst_still_idle", rd_valid, 0);
    issue_tick();
    check("restart_prime_valid", rd_valid, 0);
    check("restart_busy", frame_busy, 1);
    @(negedge clk);
    check("restart_valid", rd_valid, 1);
    check("restart_px0", rd_data, 0);
    @(negedge clk);
    check("restart_px1", rd_data, 1);
    @(negedge clk);
    check("restart_px2", rd_data, 2);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_ovr = 1'b0;

    for (int i = 0; i < 3; i++) begin
      write_frame(tbl[i].pat, 1'b0);
      issue_tick();
      check($sformatf("v%0d_busy_on", i), frame_busy, 1);
      check($sformatf("v%0d_prime_novalid", i), rd_valid, 0);
      stream_frame(tbl[i].rnd, tbl[i].pat, tbl[i].tick_a, tbl[i].clr_a, tbl[i].tick_b,
                   tbl[i].clr_b, 1'b0, npx, nbad, neol, nlast, ncyc, nside, bad_px);
      check_frame($sformatf("v%0d", i));
      if (tbl[i].exp_cyc >= 0) check($sformatf("v%0d_cycles", i), ncyc, tbl[i].exp_cyc);
      check($sformatf("v%0d_end_valid", i), rd_valid, 0);
      check($sformatf("v%0d_end_busy", i), frame_busy, 0);
      check($sformatf("v%0d_end_ovr", i), overrun, tbl[i].exp_ovr);
      if (tbl[i].exp_ovr) begin
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        exp_ovr = 1'b0;
        check($sformatf("v%0d_ovr_cleared", i), overrun, 0);
      end
    end

    // Frame B written while A streams; tick on A's last handshake
`ifdef FRAME_STREAM_PINGPONG_EN
    first_pat = 0;
`else
    first_pat = 2;
`endif
    write_frame(0, 1'b0);
    issue_tick();
    fork
      write_frame(1, 1'b1);
      stream_frame(1'b0, first_pat, -1, -1, -1, -1, 1'b1,
                   npx, nbad, neol, nlast, ncyc, nside, bad_px);
    join
    check_frame("frameA");
    check("b2b_bubble_valid", rd_valid, 0);
    check("b2b_busy_held", frame_busy, 1);
    check("b2b_ovr", overrun, 0);
    stream_frame(1'b0, 1, -1, -1, -1, -1, 1'b0, npx, nbad, neol, nlast, ncyc, nside, bad_px);
    check_frame("frameB");
    check("frameB_cycles", ncyc, 5101);
    check("frameB_end_busy", frame_busy, 0);
    check("frameB_end_ovr", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
